disp_scan: RTL and testbench
============================

DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter DIV, default 50000, clk cycles per digit slot; legal range 4..65535.
REQ-002 Parameter GUARD, default 2, leading cycles of each slot with all anodes off (anti-ghosting); legal range 1..DIV-2.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  single-cycle request to capture val/dp.
REQ-006 val  input  16  four hex digits; digit k = val[4k+3:4k], digit 0 rightmost.
REQ-007 dp  input  4  decimal point per digit, 1 = lit.
REQ-008 busy  output  1  high while a captured value is pending display.
REQ-009 frame  output  1  one-cycle pulse at each frame boundary.
REQ-010 disp_value  output  8  segments, active-low: [7]=dp, [6:0]=g,f,e,d,c,b,a.
REQ-011 disp_sel  output  4  anodes, active-low, bit k drives digit k.

Function
REQ-012 Prescaler cnt counts 0..DIV-1 and wraps; tick asserted when cnt==DIV-1.
REQ-013 Digit index idx (2 bits) increments on tick, wraps 3->0; frame boundary = tick with idx==3.
REQ-014 Slot phases: cnt<GUARD -> GUARD phase, disp_sel=4'hF, disp_value=8'hFF; otherwise ON phase, disp_sel = only bit idx low, disp_value = decode of active digit idx.
REQ-015 disp_sel and disp_value are registered: they reflect cnt/idx of the previous cycle (1-cycle latency).
REQ-016 Hex decode (dp off): 0->8'hC0, 1->8'hF9, 2->8'hA4, 3->8'hB0, 4->8'h99, 5->8'h92, 6->8'h82, 7->8'hF8, 8->8'h80, 9->8'h90, A->8'h88, b->8'h83, C->8'hC6, d->8'hA1, E->8'h86, F->8'h8E; dp lit clears bit 7.
REQ-017 load captures val/dp into pending register and sets busy on the next edge.
REQ-018 Active register (displayed) updates only at a frame boundary, from pending if busy; busy clears on the same edge.
REQ-019 load while busy overwrites pending; latest value wins; busy stays high.
REQ-020 load coincident with a frame boundary: load data goes directly to active, busy ends low.
REQ-021 frame pulses high for exactly the cycle after each frame boundary edge.
REQ-022 No mid-frame change of displayed digits (no tearing).

Reset
REQ-023 Asserting reset forces, without waiting for clk: cnt=0, idx=0, busy=0, frame=0, pending=0, active val=16'h0000, active dp=4'h0, disp_sel=4'hF, disp_value=8'hFF.
REQ-024 Reset mid-frame discards pending and active data; first slot after release starts at digit 0, GUARD phase.

Configuration
REQ-025 Macro DISP_SCAN_LZB_EN compiles in leading-zero blanking.
REQ-026 With DISP_SCAN_LZB_EN defined: digits 3..1 that are 0 and have no higher nonzero digit are blanked (8'hFF, dp still honoured); digit 0 never blanked.
REQ-027 Without DISP_SCAN_LZB_EN: every digit decoded per REQ-016; no blanking logic present.

Verification (DIV=4, GUARD=1)
REQ-028 Reset asserted mid-slot -> disp_sel=4'hF, disp_value=8'hFF immediately; busy=0.
REQ-029 load val=16'h1234 dp=4'b0000 -> busy high until next frame boundary; then slots show digit0 8'h99, digit1 8'hB0, digit2 8'hA4, digit3 8'hF9 on disp_sel 4'hE,4'hD,4'hB,4'h7.
REQ-030 Per slot: 1 cycle disp_sel=4'hF, then 3 cycles one anode low; frame pulses every 16 cycles.
REQ-031 load 16'hAAAA then 16'h5555 within one frame -> only 16'h5555 ever displayed (8'h92).
REQ-032 load 16'h0008 dp=4'b0001 on a boundary cycle -> busy stays 0; digit0 = 8'h00; LZB_EN: digits 3..1 = 8'hFF; without: 8'hC0.
REQ-033 load mid-frame 16'hFFFF -> digits already scanned this frame keep old value until frame pulse.

Source files
------------

// File: rtl/disp_scan.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan
// Description : Four-digit multiplexed 7-segment scanner. Blanked guard phase
//               at the start of each slot; new values are taken only at frame
//               boundaries. DISP_SCAN_LZB_EN adds leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan #(
    parameter int DIV   = 50000,
    parameter int GUARD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] val,
    input  logic [3:0]  dp,
    output logic        busy,
    output logic        frame,
    output logic [7:0]  disp_value,
    output logic [3:0]  disp_sel
);

    localparam logic [15:0] c_div_last = 16'(DIV - 1);
    localparam logic [15:0] c_guard    = 16'(GUARD);

    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_pend_val;
    logic [3:0]  r_pend_dp;
    logic [15:0] r_act_val;
    logic [3:0]  r_act_dp;

    logic        w_tick;
    logic        w_boundary;
    logic        w_guard;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;
    logic [6:0]  w_digit_seg;
    logic [7:0]  w_value;
    logic [3:0]  w_sel;

    assign w_tick     = (r_cnt == c_div_last);
    assign w_boundary = w_tick && (r_idx == 2'd3);
    assign w_guard    = (r_cnt < c_guard);
    assign w_nib      = r_act_val[{r_idx, 2'b00} +: 4];
    assign w_sel      = ~(4'b0001 << r_idx);

    // Segment order g,f,e,d,c,b,a, active-low
    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            default: w_seg = 7'h0E;
        endcase
    end

`ifdef DISP_SCAN_LZB_EN
    logic w_blank;

    // A digit is blank when it and every digit above it are zero; digit 0 always shows
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd3:    w_blank = (r_act_val[15:12] == 4'h0);
            2'd2:    w_blank = (r_act_val[15:8]  == 8'h00);
            2'd1:    w_blank = (r_act_val[15:4]  == 12'h000);
            default: w_blank = 1'b0;
        endcase
    end

    assign w_digit_seg = w_blank ? 7'h7F : w_seg;
`else
    assign w_digit_seg = w_seg;
`endif

    assign w_value = {~r_act_dp[r_idx], w_digit_seg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= 16'd0;
            r_idx      <= 2'd0;
            r_pend_val <= 16'h0000;
            r_pend_dp  <= 4'h0;
            r_act_val  <= 16'h0000;
            r_act_dp   <= 4'h0;
            busy       <= 1'b0;
            frame      <= 1'b0;
            disp_sel   <= 4'hF;
            disp_value <= 8'hFF;
        end else begin
            r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end
            frame      <= w_boundary;
            disp_sel   <= w_guard ? 4'hF  : w_sel;
            disp_value <= w_guard ? 8'hFF : w_value;

            // Displayed data only changes between frames so a scan never tears
            if (w_boundary) begin
                busy <= 1'b0;
                if (load) begin
                    r_act_val <= val;
                    r_act_dp  <= dp;
                end else if (busy) begin
                    r_act_val <= r_pend_val;
                    r_act_dp  <= r_pend_dp;
                end
            end else if (load) begin
                r_pend_val <= val;
                r_pend_dp  <= dp;
                busy       <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_scan
// Description : Directed bench for disp_scan (DIV=4, GUARD=1) with an
//               expected-output queue per frame window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scan;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] val;
    logic [3:0]  dp;
    logic        busy;
    logic        frame;
    logic [7:0]  disp_value;
    logic [3:0]  disp_sel;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] value;
    } exp_t;

    exp_t exp_q[$];

    disp_scan #(.DIV(4), .GUARD(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .val        (val),
        .dp         (dp),
        .busy       (busy),
        .frame      (frame),
        .disp_value (disp_value),
        .disp_sel   (disp_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] hex_code(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] expect_digit(input logic [15:0] v, input logic [3:0] d, input int k);
        logic [15:0] upper;
        logic [7:0]  code;
        upper = v >> (4 * k);
        code  = hex_code(upper[3:0]);
`ifdef DISP_SCAN_LZB_EN
        if (k > 0 && upper == 16'h0000) code = 8'hFF;
`endif
        if (d[k]) code[7] = 1'b0;
        return code;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (frame === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_frame_timeout observed=no_frame expected=frame_pulse", tag);
        end
    endtask

    // Entered on a frame-pulse cycle; checks the 16 cycles up to the next pulse.
    task automatic run_frame(input string tag,
                             input logic [15:0] ev, input logic [3:0] ed,
                             input int la1, input logic [15:0] lv1, input logic [3:0] ld1,
                             input int la2, input logic [15:0] lv2, input logic [3:0] ld2);
        exp_t e;
        bit   pend;
        for (int i = 1; i <= 16; i++) begin
            int slot;
            slot = (i - 1) / 4;
            if ((i - 1) % 4 == 0) begin
                e.sel   = 4'hF;
                e.value = 8'hFF;
            end else begin
                e.sel   = ~(4'b0001 << slot);
                e.value = expect_digit(ev, ed, slot);
            end
            exp_q.push_back(e);
        end
        pend = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            e = exp_q.pop_front();
            check($sformatf("%s_sel_c%0d", tag, i), {12'h0, disp_sel}, {12'h0, e.sel});
            check($sformatf("%s_val_c%0d", tag, i), {8'h0, disp_value}, {8'h0, e.value});
            check($sformatf("%s_frame_c%0d", tag, i), {15'h0, frame}, {15'h0, (i == 16)});
            check($sformatf("%s_busy_c%0d", tag, i), {15'h0, busy}, {15'h0, (pend && i < 16)});
            if (i == la1) begin
                load = 1'b1; val = lv1; dp = ld1; pend = 1'b1;
            end else if (i == la2) begin
                load = 1'b1; val = lv2; dp = ld2; pend = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        val   = 16'h0000;
        dp    = 4'h0;
        repeat (3) step();
        check("rst_sel",   {12'h0, disp_sel},   16'h000F);
        check("rst_val",   {8'h0, disp_value},  16'h00FF);
        check("rst_busy",  {15'h0, busy},       16'h0000);
        check("rst_frame", {15'h0, frame},      16'h0000);
        reset = 1'b0;

        wait_frame("sync0");
        run_frame("zero",  16'h0000, 4'h0, 3,  16'h1234, 4'b0000, 0, 16'h0, 4'h0);
        run_frame("v1234", 16'h1234, 4'h0, 2,  16'hAAAA, 4'b0000, 5, 16'h5555, 4'b0000);
        run_frame("v5555", 16'h5555, 4'h0, 15, 16'h0008, 4'b0001, 0, 16'h0, 4'h0);
        run_frame("v0008", 16'h0008, 4'h1, 6,  16'hFFFF, 4'b0000, 0, 16'h0, 4'h0);
        run_frame("vFFFF", 16'hFFFF, 4'h0, 0,  16'h0000, 4'h0,    0, 16'h0, 4'h0);

        // Pending value then asynchronous reset in the middle of a cycle
        load = 1'b1; val = 16'h9999; dp = 4'hF;
        step();
        load = 1'b0;
        check("pre_rst_busy", {15'h0, busy}, 16'h0001);
        step();
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_sel",   {12'h0, disp_sel},  16'h000F);
        check("async_rst_val",   {8'h0, disp_value}, 16'h00FF);
        check("async_rst_busy",  {15'h0, busy},      16'h0000);
        check("async_rst_frame", {15'h0, frame},     16'h0000);
        step();
        step();
        reset = 1'b0;
        step();
        check("post_rst_guard_sel", {12'h0, disp_sel},  16'h000F);
        check("post_rst_guard_val", {8'h0, disp_value}, 16'h00FF);
        step();
        check("post_rst_d0_sel", {12'h0, disp_sel},  16'h000E);
        check("post_rst_d0_val", {8'h0, disp_value}, 16'h00C0);
        wait_frame("sync1");
        run_frame("after_rst", 16'h0000, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
